// File: rtl/aes_inv.sv
// aes_inv: iterative AES-128 decryptor, one round per clock.
// The decryptor is given the original cipher key. It first runs the forward key
// schedule up to rk10, then walks the schedule backwards one step per round
// while the state is decrypted. No round-key storage is needed.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous, active-high reset
//   C        ciphertext block, bits [127:120] = byte 0, column-major
//   K        cipher key (round key 0), same byte order
//   in_valid request; C/K are sampled when in_valid && ready
//   ready    high only while idle
//   P        registered plaintext, held until the next completed block or reset
//   valid    one-cycle pulse when P is updated (21 edges after accept)
module aes_inv (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] C,
  input  logic [127:0] K,
  input  logic         in_valid,
  output logic         ready,
  output logic [127:0] P,
  output logic         valid
);

  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} fsm_t;
  typedef logic [15:0][7:0] bytes_t;   // element [15] is byte 0

  fsm_t         r_fsm, w_fsm_nxt;
  logic [127:0] r_blk;
  logic [127:0] r_key;
  logic [3:0]   r_rnd;
  logic [127:0] r_p;
  logic         r_valid;

  // ---------------- GF(2^8) / S-box helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    t = ginv(a);
    return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]}
             ^ {t[3:0], t[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  // ---------------- round transforms ----------------
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    bytes_t i, o;
    i = s;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[4'(15 - (4*c + r))] = i[4'(15 - (4*((c + 4 - r) % 4) + r))];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    bytes_t i, o;
    i = s;
    o = '0;
    for (int unsigned n = 0; n < 16; n++)
      o[4'(n)] = inv_sbox(i[4'(n)]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    bytes_t i, o;
    logic [7:0] a0, a1, a2, a3;
    i = s;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = i[4'(15 - 4*c)];
      a1 = i[4'(14 - 4*c)];
      a2 = i[4'(13 - 4*c)];
      a3 = i[4'(12 - 4*c)];
      o[4'(15 - 4*c)] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[4'(14 - 4*c)] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[4'(13 - 4*c)] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[4'(12 - 4*c)] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------- key schedule ----------------
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] rc;
    case (i)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // SubWord(RotWord(w))
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Inverse of key_fwd: recover rk_{i-1} from rk_i using Rcon_i.
  function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0]  ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_rot(n3) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    ready     = 1'b0;
    case (r_fsm)
      IDLE: begin
        ready = 1'b1;
        if (in_valid) w_fsm_nxt = KEXP;
      end
      KEXP:    if (r_rnd == 4'd10) w_fsm_nxt = INIT;
      INIT:    w_fsm_nxt = ROUND;
      ROUND:   if (r_rnd == 4'd1) w_fsm_nxt = FINAL;
      FINAL:   w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // r_rnd counts 1..10 during expansion and stays at 10 so that INIT uses
  // Rcon_10 for the first backward step; it then counts down to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk   <= '0;
      r_key   <= '0;
      r_rnd   <= '0;
      r_p     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_blk <= C;
            r_key <= K;
            r_rnd <= 4'd1;
          end
        end
        KEXP: begin
          r_key <= key_fwd(r_key, rcon(r_rnd));
          if (r_rnd != 4'd10) r_rnd <= r_rnd + 4'd1;
        end
        INIT: begin
          r_blk <= r_blk ^ r_key;
          r_key <= key_bwd(r_key, rcon(r_rnd));
          r_rnd <= r_rnd - 4'd1;
        end
        ROUND: begin
          r_blk <= inv_mix(inv_sub(inv_shift(r_blk)) ^ r_key);
          r_key <= key_bwd(r_key, rcon(r_rnd));
          r_rnd <= r_rnd - 4'd1;
        end
        FINAL: begin
          r_p     <= inv_sub(inv_shift(r_blk)) ^ r_key;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign P     = r_p;
  assign valid = r_valid;

endmodule
